main_reset_gen: RTL

MAIN_RESET_GEN -- requirements
Module: main_reset_gen

---
 rtl/main_reset_gen_if.sv | 21 ++
 rtl/main_reset_gen.sv | 126 ++++++++++++
 2 files changed

// File: rtl/main_reset_gen_if.sv
// Handshake bundle for the reset generator: PLL lock/clear inputs and the
// sequenced reset and status outputs.
interface main_reset_gen_if;
  logic       pll_locked;
  logic       lock_lost_clr;
  logic       reset_core_n;
  logic       reset_periph_n;
  logic       ready;
  logic       lock_lost;
  logic [7:0] lock_loss_cnt;

  modport master (
    output pll_locked, lock_lost_clr,
    input  reset_core_n, reset_periph_n, ready, lock_lost, lock_loss_cnt
  );

  modport slave (
    input  pll_locked, lock_lost_clr,
    output reset_core_n, reset_periph_n, ready, lock_lost, lock_loss_cnt
  );
endinterface

// File: rtl/main_reset_gen.sv
// Sequences core and peripheral reset release after the main PLL has held lock
// long enough, and records lock losses seen once the core is running.
module main_reset_gen #(
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned PERIPH_DELAY  = 256
) (
  input  logic             clk,
  input  logic             reset_n,
  main_reset_gen_if.slave  bus
);

  typedef enum logic [1:0] {WAIT_LOCK, STABILIZE, CORE_UP, ALL_UP} state_t;

  localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);
  localparam logic [15:0] PERIPH_LAST = 16'(PERIPH_DELAY - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  sync_q, sync_d;
  logic        core_q, core_d;
  logic        periph_q, periph_d;
  logic        ready_q, ready_d;
  logic        lost_q, lost_d;
  logic [7:0]  loss_cnt_q, loss_cnt_d;
  logic        locked_s;
  logic        loss_event;

  // pll_locked is asynchronous to clk; only the second stage is ever used.
  assign sync_d   = {sync_q[0], bus.pll_locked};
  assign locked_s = sync_q[1];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    loss_event = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (locked_s) state_d = STABILIZE;
      end
      STABILIZE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = CORE_UP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      CORE_UP: begin
        if (!locked_s) begin
          state_d    = WAIT_LOCK;
          cnt_d      = '0;
          loss_event = 1'b1;
        end else if (cnt_q == PERIPH_LAST) begin
          state_d = ALL_UP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ALL_UP: begin
        if (!locked_s) begin
          state_d    = WAIT_LOCK;
          cnt_d      = '0;
          loss_event = 1'b1;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  // Reset outputs follow the next state so they change on the same edge.
  always_comb begin
    core_d   = (state_d == CORE_UP) || (state_d == ALL_UP);
    periph_d = (state_d == ALL_UP);
    ready_d  = (state_d == ALL_UP);
  end

  // A clear coinciding with a loss keeps that loss as the first new event.
  always_comb begin
    lost_d     = lost_q;
    loss_cnt_d = loss_cnt_q;
    if (bus.lock_lost_clr) begin
      lost_d     = loss_event;
      loss_cnt_d = loss_event ? 8'd1 : 8'd0;
    end else if (loss_event) begin
      lost_d = 1'b1;
      if (loss_cnt_q != 8'hFF) loss_cnt_d = loss_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= WAIT_LOCK;
      cnt_q      <= '0;
      sync_q     <= '0;
      core_q     <= 1'b0;
      periph_q   <= 1'b0;
      ready_q    <= 1'b0;
      lost_q     <= 1'b0;
      loss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sync_q     <= sync_d;
      core_q     <= core_d;
      periph_q   <= periph_d;
      ready_q    <= ready_d;
      lost_q     <= lost_d;
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign bus.reset_core_n   = core_q;
  assign bus.reset_periph_n = periph_q;
  assign bus.ready          = ready_q;
  assign bus.lock_lost      = lost_q;
  assign bus.lock_loss_cnt  = loss_cnt_q;

endmodule
